// File: rtl/serial_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_add_seq : bit-serial adder driving an external full-adder cell      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_add_seq #(
  parameter int WIDTH  = 8,
  parameter int FA_LAT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, a_sh_n, b_sh, b_sh_n, sum_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [3:0]       slot, slot_n;
  logic             fa_a_n, fa_b_n, fa_c_n, valid_n, cout_n;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      idx       <= '0;
      slot      <= '0;
      fa_a      <= 1'b0;
      fa_b      <= 1'b0;
      fa_c      <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      a_sh      <= a_sh_n;
      b_sh      <= b_sh_n;
      idx       <= idx_n;
      slot      <= slot_n;
      fa_a      <= fa_a_n;
      fa_b      <= fa_b_n;
      fa_c      <= fa_c_n;
      out_sum   <= sum_n;
      out_cout  <= cout_n;
      out_valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    a_sh_n  = a_sh;
    b_sh_n  = b_sh;
    idx_n   = idx;
    slot_n  = slot;
    fa_a_n  = fa_a;
    fa_b_n  = fa_b;
    fa_c_n  = fa_c;
    sum_n   = out_sum;
    cout_n  = out_cout;
    valid_n = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = RUN;
          // Operands are kept pre-shifted so the next bit is always at [0].
          a_sh_n  = in_a >> 1;
          b_sh_n  = in_b >> 1;
          fa_a_n  = in_a[0];
          fa_b_n  = in_b[0];
          fa_c_n  = in_cin;
          idx_n   = '0;
          slot_n  = '0;
          sum_n   = '0;
          cout_n  = 1'b0;
        end
      end
      RUN: begin
        if (slot == 4'(FA_LAT)) begin
          slot_n     = '0;
          sum_n[idx] = fa_s;
          if (idx == IDX_W'(WIDTH - 1)) begin
            cout_n  = fa_cout;
            valid_n = 1'b1;
            state_n = DONE;
          end else begin
            idx_n  = idx + 1'b1;
            fa_a_n = a_sh[0];
            fa_b_n = b_sh[0];
            fa_c_n = fa_cout;
            a_sh_n = a_sh >> 1;
            b_sh_n = b_sh >> 1;
          end
        end else begin
          slot_n = slot + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_add_seq : directed-vector bench with full-adder cell models      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // WIDTH=8, FA_LAT=6 instance
  logic       in_valid, in_ready, in_cin, fa_a, fa_b, fa_c, fa_s, fa_cout;
  logic       out_valid, out_ready, out_cout;
  logic [7:0] in_a, in_b, out_sum;
  logic [1:0] d8 [0:5];

  serial_add_seq #(.WIDTH(8), .FA_LAT(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
  );

  // Full-adder cell whose outputs follow its inputs after 6 edges
  always @(posedge clk) begin
    d8[0] <= {(fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c), fa_a ^ fa_b ^ fa_c};
    for (int i = 1; i < 6; i++) d8[i] <= d8[i-1];
  end
  assign fa_s    = d8[5][0];
  assign fa_cout = d8[5][1];

  // WIDTH=4, FA_LAT=0 instance with a purely combinational cell
  logic       in_valid4, in_ready4, in_cin4, fa_a4, fa_b4, fa_c4, fa_s4, fa_cout4;
  logic       out_valid4, out_ready4, out_cout4;
  logic [3:0] in_a4, in_b4, out_sum4;

  serial_add_seq #(.WIDTH(4), .FA_LAT(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_c(fa_c4), .fa_s(fa_s4), .fa_cout(fa_cout4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4), .out_cout(out_cout4)
  );
  assign fa_s4    = fa_a4 ^ fa_b4 ^ fa_c4;
  assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_c4) | (fa_b4 & fa_c4);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;
  vec_t vecs [9];

  // Caller is at a negedge; acceptance happens at the next posedge.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] esum, input logic ecout, input bit release_it);
    int edges;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk); #1;
    check("sum_cleared", out_sum, 0);
    check("busy", {in_ready, out_valid}, 0);
    check("fa_load", {fa_a, fa_b, fa_c}, {a[0], b[0], cin});
    @(negedge clk);
    in_valid = 1'b1; in_a = ~a; in_b = a ^ b; in_cin = ~cin;  // must be ignored
    edges = 0;
    while (!out_valid && edges < 1000) begin
      @(posedge clk); #1;
      edges++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("latency", edges, 56);
    check("sum", out_sum, esum);
    check("cout", out_cout, ecout);
    if (release_it) begin
      @(posedge clk); #1;
      check("release", {out_valid, in_ready}, 2'b01);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] cseq;
    int edges;
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 1;
    in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_cin4 = 0; out_ready4 = 1;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    repeat (8) @(posedge clk);
    #1;
    check("rst_state", {in_ready, out_valid, out_cout, fa_a, fa_b, fa_c}, 6'b100000);
    check("rst_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, 1'b1);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    run_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
      @(posedge clk); #1;
      check("hold", {out_valid, in_ready, out_sum, out_cout}, {2'b10, 8'h96, 1'b0});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {out_valid, in_ready}, 2'b01);
    @(negedge clk);

    // Reset in the middle of an operation
    in_valid = 1'b1; in_a = 8'h5A; in_b = 8'h3C; in_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre_rst_partial", out_sum, 8'h02);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {in_ready, out_valid, out_cout, fa_a, fa_b, fa_c}, 6'b100000);
    check("mid_rst_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);

    // One-cycle slots on the 4-bit instance
    in_valid4 = 1'b1; in_a4 = 4'h9; in_b4 = 4'h8; in_cin4 = 1'b1;
    @(posedge clk); #1;
    cseq = '0;
    cseq[3] = fa_c4;
    @(negedge clk);
    in_valid4 = 1'b0;
    edges = 0;
    while (!out_valid4 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (edges < 4) cseq[3-edges] = fa_c4;
    end
    check("l0_latency", edges, 4);
    check("l0_sum", out_sum4, 4'h2);
    check("l0_cout", out_cout4, 1);
    check("l0_fa_c_seq", cseq, 4'b1100);
    @(posedge clk); #1;
    check("l0_release", {out_valid4, in_ready4}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal range 1..64.
REQ-002 Parameter FA_LAT, default 6: clock edges from a change on fa_a/fa_b/fa_c to valid fa_s/fa_cout at the downstream full-adder cell; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 in_a  input  WIDTH  addend A.
REQ-008 in_b  input  WIDTH  addend B.
REQ-009 in_cin  input  1  carry-in.
REQ-010 fa_a  output  1  bit of A driven to the full-adder cell.
REQ-011 fa_b  output  1  bit of B driven to the full-adder cell.
REQ-012 fa_c  output  1  carry driven to the full-adder cell.
REQ-013 fa_s  input  1  sum returned by the full-adder cell.
REQ-014 fa_cout  input  1  carry returned by the full-adder cell.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
REQ-018 out_cout  output  1  carry out of bit WIDTH-1.

Function
REQ-019 The state machine SHALL have exactly three states: IDLE, RUN, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-021 IDLE->RUN on an edge with in_valid=1; the same edge latches in_a, in_b, in_cin and loads fa_a=in_a[0], fa_b=in_b[0], fa_c=in_cin, bit index=0, slot counter=0.
REQ-022 fa_a/fa_b/fa_c SHALL be registered outputs held constant for a full slot of FA_LAT+1 cycles.
REQ-023 In RUN the slot counter SHALL increment each edge; on the edge where it equals FA_LAT it SHALL clear, write fa_s into out_sum[index], and take fa_cout as the next carry.
REQ-024 On that capture edge, if index<WIDTH-1: index increments and fa_a/fa_b/fa_c load bit index+1 of A and B and the captured carry.
REQ-025 On that capture edge, if index=WIDTH-1: out_cout=fa_cout, state->DONE, out_valid=1.
REQ-026 Latency: out_valid SHALL first be visible after exactly WIDTH*(FA_LAT+1) edges following the acceptance edge.
REQ-027 In DONE, out_sum/out_cout/out_valid SHALL hold stable until an edge with out_ready=1, which sets out_valid=0 and state->IDLE.
REQ-028 No back-to-back overlap: in_ready is 0 during the DONE->IDLE edge; the next acceptance occurs no earlier than the following edge.
REQ-029 in_valid, in_a, in_b and in_cin SHALL be ignored outside IDLE; fa_s/fa_cout SHALL be ignored except on capture edges.
REQ-030 Bits of out_sum not yet written in RUN SHALL read 0; out_sum is cleared on acceptance.
REQ-031 FA_LAT=0 SHALL give one-cycle slots: capture on every edge in RUN.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, in_ready=1 (once combinational), out_valid=0, out_sum=0, out_cout=0, fa_a=fa_b=fa_c=0, counters=0.
REQ-033 Reset during RUN or DONE SHALL abort the operation with no result delivered; the first edge after rst_n rises SHALL be able to accept new operands.

Verification (WIDTH=8, FA_LAT=6, bench models the full-adder cell with 6-edge latency)
REQ-034 A=0x5A, B=0x3C, cin=0, out_ready=1 -> out_sum=0x96, out_cout=0, out_valid visible exactly 56 edges after acceptance.
REQ-035 A=0xFF, B=0x01, cin=0 -> out_sum=0x00, out_cout=1; A=0xFF, B=0xFF, cin=1 -> out_sum=0xFF, out_cout=1.
REQ-036 Result 0x96 with out_ready=0 for 10 cycles -> out_valid and out_sum held; in_ready=0 throughout; release in 1 cycle after out_ready=1.
REQ-037 rst_n pulsed low at edge 20 of an operation -> all outputs 0 at once, no out_valid; next operand set 0x01+0x01 -> 0x02.
REQ-038 FA_LAT=0, WIDTH=4, A=0x9, B=0x8, cin=1 -> out_sum=0x2, out_cout=1, after 4 edges; fa_c sequence 1,1,0,0 observed.
